pc_gen_ras: RTL and testbench
=============================

// Module: pc_gen_ras
// PURPOSE
//  Parametrised fetch program-counter generator for the rv32i cores; successor of the single-cycle PC.
//  Holds the word-addressed fetch PC and advances it with stall, branch redirect and trap-vector entry.
//  Includes a DEPTH-entry return-address stack (RAS): call pushes the return address, ret predicts the target.
//  Sits between the instruction memory address port and the decode/execute redirect logic.
// PARAMETERS
//  WIDTH      30           PC width in words (byte address = {pc, 2'b00})
//  STEP       1            sequential increment, in words
//  RESET_VEC  0            PC value loaded by reset
//  TRAP_VEC   'h1          PC value loaded on trap
//  DEPTH      4            RAS entries, >=2, power of two
// PORTS
//  clk           in   1          clock; all state updates on posedge
//  rst           in   1          asynchronous, active-high reset
//  stall         in   1          hold PC (ignored when trap/redirect asserted)
//  trap          in   1          jump to TRAP_VEC
//  redirect      in   1          jump to redirect_addr
//  redirect_addr in   WIDTH      redirect target
//  call          in   1          current instr is a call: push pc+STEP onto RAS
//  ret           in   1          current instr is a return: pop RAS, use as next PC
//  pc            out  WIDTH      current fetch PC
//  pc_seq        out  WIDTH      pc + STEP (combinational, mod 2^WIDTH)
//  pc_valid      out  1          pc holds a valid fetch address
//  ras_empty     out  1          RAS count == 0
//  ras_full      out  1          RAS count == DEPTH
//  ret_miss      out  1          one-cycle pulse: ret seen with RAS empty
// BEHAVIOUR
//  - Reset (async): pc=RESET_VEC, pc_valid=0, RAS count=0, top pointer=0, ret_miss=0; entries undefined.
//  - First posedge with rst low: pc_valid<=1, pc unchanged (RESET_VEC is the first fetch).
//  - While pc_valid=1, next PC per posedge, strict priority:
//      1 trap          -> TRAP_VEC
//      2 redirect      -> redirect_addr
//      3 stall         -> pc (hold)
//      4 ret, RAS non-empty -> RAS top
//      5 otherwise     -> pc_seq (includes ret with RAS empty)
//  - Latency: new PC visible on pc one cycle after the controlling input is sampled.
//  - RAS updates only on a posedge where trap=0, redirect=0, stall=0, pc_valid=1.
//  - call only: write pc_seq at top+1, top<=top+1, count<=min(count+1,DEPTH).
//    Push when full overwrites the oldest entry (circular); count stays DEPTH.
//  - ret only, non-empty: next PC=entry[top], top<=top-1, count<=count-1.
//  - ret only, empty: PC advances sequentially, ret_miss=1 for that cycle (registered, cleared next edge), RAS unchanged.
//  - call+ret same cycle: next PC=entry[top] (if non-empty, else pc_seq + ret_miss);
//    then entry[top]<=pc_seq (replace in place); count unchanged (empty: becomes 1).
//  - Pointers wrap modulo DEPTH; PC arithmetic wraps modulo 2^WIDTH, no overflow flag.
//  - rst asserted mid-operation clears everything immediately regardless of clk.
//  - ras_empty/ras_full are combinational decodes of count.
// TESTING
//  1 Reset: rst=1 -> pc=RESET_VEC, pc_valid=0; release -> 1st edge pc_valid=1 pc=0, then 1,2,3.
//  2 Priority: pc=5, trap=1 & redirect=1 (addr 'h40) & stall=1 -> pc='h1; redirect alone -> 'h40.
//  3 Call/ret: pc=8 call -> pc=9; redirect 'h20; ret at 'h20 -> pc=9, ras_empty=1.
//  4 Overflow: DEPTH=4, calls at pc 1,3,5,7,9 -> ras_full=1; 4 rets return 10,8,6,4 then ret_miss on 5th.
//  5 Empty ret: reset, ret at pc=2 -> pc=3, ret_miss=1 one cycle, ras_empty stays 1.
//  6 Wrap/stall: WIDTH=4, pc='hF -> pc=0; stall+call at pc=3 -> pc=3, RAS count unchanged.

Source files
------------

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC generator with trap/redirect/stall priority and a circular return-address stack.
// The RAS keeps a top pointer plus an occupancy count; a push when full silently overwrites the oldest entry.
module pc_gen_ras #(
    parameter int WIDTH = 30,
    parameter int STEP = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(1),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             miss_q, miss_d;
    logic [WIDTH-1:0] ras_q [DEPTH];
    logic             upd, empty, push, pop, repl;

    assign pc_seq    = pc_q + WIDTH'(STEP);
    assign empty     = cnt_q == '0;
    assign ras_empty = empty;
    assign ras_full  = cnt_q == CW'(DEPTH);
    assign pc        = pc_q;
    assign pc_valid  = valid_q;
    assign ret_miss  = miss_q;

    // The stack only moves on a cycle that actually retires into sequential/return flow.
    assign upd  = valid_q & ~trap & ~redirect & ~stall;
    assign push = upd & call & ~ret;
    assign pop  = upd & ret & ~call & ~empty;
    assign repl = upd & call & ret;

    always_comb begin
        pc_d   = ~valid_q ? pc_q :
                 trap     ? TRAP_VEC :
                 redirect ? redirect_addr :
                 stall    ? pc_q :
                 (ret & ~empty) ? ras_q[top_q] : pc_seq;
        top_d  = push ? top_q + PW'(1) : pop ? top_q - PW'(1) : top_q;
        cnt_d  = push ? (ras_full ? cnt_q : cnt_q + CW'(1)) :
                 pop  ? cnt_q - CW'(1) :
                 (repl & empty) ? CW'(1) : cnt_q;
        miss_d = upd & ret & empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            top_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
        end
    end

    // Entries carry no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            ras_q[top_q + PW'(1)] <= pc_seq;
        else if (repl)
            ras_q[top_q] <= pc_seq;
    end
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: scoreboard bench; a queue-based stack model predicts each post-edge state.
module tb_pc_gen_ras;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic       stall = 0, trap = 0, redirect = 0, call = 0, ret = 0;
    logic [7:0] redirect_addr = '0;
    logic [7:0] pc, pc_seq;
    logic       pc_valid, ras_empty, ras_full, ret_miss;

    pc_gen_ras #(.WIDTH(8), .STEP(1), .RESET_VEC(8'h00), .TRAP_VEC(8'h01), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .redirect(redirect),
        .redirect_addr(redirect_addr), .call(call), .ret(ret), .pc(pc), .pc_seq(pc_seq),
        .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full), .ret_miss(ret_miss)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] seq;
        logic       v, e, f, m;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0;
    logic [7:0] m_pc;
    logic       m_valid, m_miss;
    logic [7:0] stk[$];

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", n, a, b, $time);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.pc  = m_pc;
        e.seq = m_pc + 8'd1;
        e.v   = m_valid;
        e.e   = stk.size() == 0;
        e.f   = stk.size() == DEPTH;
        e.m   = m_miss;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_valid = 0; m_miss = 0; stk.delete();
    endtask

    task automatic model_step();
        logic [7:0] seq, np;
        seq = m_pc + 8'd1;
        if (!m_valid) begin
            m_valid = 1; m_miss = 0;
            return;
        end
        m_miss = 0;
        if (trap) m_pc = 8'h01;
        else if (redirect) m_pc = redirect_addr;
        else if (!stall) begin
            np = (ret && stk.size() > 0) ? stk[$] : seq;
            m_miss = ret && stk.size() == 0;
            if (call && ret) begin
                if (stk.size() > 0) stk[$] = seq; else stk.push_back(seq);
            end else if (call) begin
                stk.push_back(seq);
                if (stk.size() > DEPTH) void'(stk.pop_front());
            end else if (ret && stk.size() > 0) void'(stk.pop_back());
            m_pc = np;
        end
    endtask

    // Called at a negedge: drive inputs, predict the next edge, then wait for the next negedge.
    task automatic step(input logic t, input logic r, input logic [7:0] a, input logic s,
                        input logic c, input logic rt);
        trap = t; redirect = r; redirect_addr = a; stall = s; call = c; ret = rt;
        model_step();
        q.push_back(cur_exp());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic check_reset_state();
        chk("rst_pc", pc, 8'h00);
        chk("rst_valid", {7'd0, pc_valid}, 8'd0);
        chk("rst_empty", {7'd0, ras_empty}, 8'd1);
        chk("rst_miss", {7'd0, ret_miss}, 8'd0);
    endtask

    // Asynchronous reset asserted between edges, released at the following negedge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1;
        #1 check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_seq", pc_seq, e.seq);
                chk("pc_valid", {7'd0, pc_valid}, {7'd0, e.v});
                chk("ras_empty", {7'd0, ras_empty}, {7'd0, e.e});
                chk("ras_full", {7'd0, ras_full}, {7'd0, e.f});
                chk("ret_miss", {7'd0, ret_miss}, {7'd0, e.m});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 0;
        idle(4);
        step(0, 1, 8'h05, 0, 0, 0);
        step(1, 1, 8'h40, 1, 0, 0);
        step(0, 1, 8'h40, 0, 0, 0);
        step(0, 1, 8'h08, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        step(0, 1, 8'h20, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 8'(2 * k + 1), 0, 0, 0);
            step(0, 0, 8'h00, 0, 1, 0);
        end
        for (int k = 0; k < 5; k++) step(0, 0, 8'h00, 0, 0, 1);
        idle(1);
        do_reset();
        idle(3);
        step(0, 0, 8'h00, 0, 0, 1);
        idle(2);
        step(0, 1, 8'hFF, 0, 0, 0);
        idle(1);
        step(0, 1, 8'h03, 0, 0, 0);
        step(0, 0, 8'h00, 1, 1, 0);
        step(0, 0, 8'h00, 0, 1, 1);
        step(0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, 8'($urandom),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
